// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_mp : multi-port register file, write bypass, zero reg, busy bits  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD*ADDR_W-1:0]  rreg,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rready,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*ADDR_W-1:0] wreg,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_reg,
  output logic [2**ADDR_W-1:0]     busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;

  logic [ADDR_W-1:0] w_wreg  [NWRITE];
  logic [DATA_W-1:0] w_wdata [NWRITE];
  logic [NWRITE-1:0] w_weff;

  generate
    for (genvar j = 0; j < NWRITE; j++) begin : g_wport
      assign w_wreg[j]  = wreg[j*ADDR_W +: ADDR_W];
      assign w_wdata[j] = wdata[j*DATA_W +: DATA_W];
      // Reset and register 0 both suppress the write, and with it the bypass.
      assign w_weff[j]  = wen[j] & (w_wreg[j] != '0) & ~reset;
    end
  endgenerate

  // Alloc is applied after the write clears so a same-edge new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (w_weff[j]) w_busy_nxt[w_wreg[j]] = 1'b0;
    end
    if (alloc_en && (alloc_reg != '0)) w_busy_nxt[alloc_reg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      // Ascending port order: the highest-indexed colliding writer lands last.
      for (int j = 0; j < NWRITE; j++) begin
        if (w_weff[j]) r_mem[w_wreg[j]] <= w_wdata[j];
      end
    end
  end

  generate
    for (genvar k = 0; k < NREAD; k++) begin : g_rport
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_rdy;

      assign w_ra = rreg[k*ADDR_W +: ADDR_W];

      always_comb begin
        w_rd  = r_mem[w_ra];
        w_rdy = ~r_busy[w_ra];
        for (int j = 0; j < NWRITE; j++) begin
          if (w_weff[j] && (w_wreg[j] == w_ra)) begin
            w_rd  = w_wdata[j];
            w_rdy = 1'b1;
          end
        end
        if (w_ra == '0) begin
          w_rd  = '0;
          w_rdy = 1'b1;
        end
      end

      assign rdata[k*DATA_W +: DATA_W] = w_rd;
      assign rready[k]                 = w_rdy;
    end
  endgenerate

  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_mp : directed vector table plus randomized model comparison    |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rreg;
  logic [63:0] rdata;
  logic [1:0]  rready;
  logic [1:0]  wen;
  logic [9:0]  wreg;
  logic [63:0] wdata;
  logic        alloc_en;
  logic [4:0]  alloc_reg;
  logic [31:0] busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rreg      (rreg),
    .rdata     (rdata),
    .rready    (rready),
    .wen       (wen),
    .wreg      (wreg),
    .wdata     (wdata),
    .alloc_en  (alloc_en),
    .alloc_reg (alloc_reg),
    .busy      (busy)
  );

  typedef struct {
    bit        rst;
    bit [1:0]  wen;
    bit [4:0]  wr0;
    bit [31:0] wd0;
    bit [4:0]  wr1;
    bit [31:0] wd1;
    bit        ae;
    bit [4:0]  ar;
    bit [4:0]  rr0;
    bit [4:0]  rr1;
    bit        chk;
    bit [31:0] ed0;
    bit [31:0] ed1;
    bit [1:0]  erdy;
    bit [31:0] ebusy;
  } vec_t;

  function automatic vec_t mk(bit rst, bit [1:0] w, bit [4:0] wr0, bit [31:0] wd0,
                              bit [4:0] wr1, bit [31:0] wd1, bit ae, bit [4:0] ar,
                              bit [4:0] rr0, bit [4:0] rr1, bit chk, bit [31:0] ed0,
                              bit [31:0] ed1, bit [1:0] erdy, bit [31:0] ebusy);
    vec_t v;
    v.rst = rst; v.wen = w; v.wr0 = wr0; v.wd0 = wd0; v.wr1 = wr1; v.wd1 = wd1;
    v.ae = ae; v.ar = ar; v.rr0 = rr0; v.rr1 = rr1; v.chk = chk;
    v.ed0 = ed0; v.ed1 = ed1; v.erdy = erdy; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(bit rst, bit [1:0] w, bit [4:0] wr0, bit [31:0] wd0,
                       bit [4:0] wr1, bit [31:0] wd1, bit ae, bit [4:0] ar,
                       bit [4:0] rr0, bit [4:0] rr1);
    reset = rst; wen = w; wreg = {wr1, wr0}; wdata = {wd1, wd0};
    alloc_en = ae; alloc_reg = ar; rreg = {rr1, rr0};
  endtask

  // Reference model: architectural state only.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  function automatic void model_read(bit rst, bit [1:0] w, bit [4:0] wr0, bit [31:0] wd0,
                                     bit [4:0] wr1, bit [31:0] wd1, bit [4:0] a,
                                     output logic [31:0] d, output logic rdy);
    if (a == 0) begin
      d = 0; rdy = 1;
    end else if (!rst && w[1] && wr1 == a) begin
      d = wd1; rdy = 1;
    end else if (!rst && w[0] && wr0 == a) begin
      d = wd0; rdy = 1;
    end else begin
      d = m_mem[a]; rdy = !m_busy[a];
    end
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = m_busy[i];
    return b;
  endfunction

  vec_t vecs [20];

  initial begin
    vecs[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    vecs[1]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 2'b11, 0);
    vecs[2]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 31, 0, 1, 0, 0, 2'b11, 0);
    vecs[3]  = mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 0);
    vecs[4]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 7, 1, 32'hDEADBEEF, 0, 2'b11, 0);
    vecs[5]  = mk(0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 5, 1, 32'h22, 32'hDEADBEEF, 2'b11, 0);
    vecs[6]  = mk(0, 2'b01, 0, 32'hFF, 0, 0, 0, 0, 0, 7, 1, 0, 32'h22, 2'b11, 0);
    vecs[7]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 7, 1, 0, 32'h22, 2'b11, 0);
    vecs[8]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 1, 0, 0, 2'b00, 32'h200);
    vecs[9]  = mk(0, 2'b10, 0, 0, 9, 32'h1234, 0, 0, 9, 5, 1, 32'h1234, 32'hDEADBEEF, 2'b11, 32'h200);
    vecs[10] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 3, 1, 32'h1234, 0, 2'b11, 0);
    vecs[11] = mk(0, 2'b01, 3, 32'h55, 0, 0, 1, 3, 3, 9, 1, 32'h55, 32'h1234, 2'b11, 0);
    vecs[12] = mk(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0, 1, 32'h55, 0, 2'b10, 32'h8);
    vecs[13] = mk(0, 2'b01, 3, 32'h66, 0, 0, 0, 0, 3, 3, 1, 32'h66, 32'h66, 2'b11, 32'h8);
    vecs[14] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 7, 1, 32'h66, 32'h22, 2'b11, 0);
    vecs[15] = mk(0, 2'b11, 1, 32'hA, 2, 32'hB, 1, 2, 1, 2, 1, 32'hA, 32'hB, 2'b11, 0);
    vecs[16] = mk(0, 2'b11, 3, 32'hC, 4, 32'hD, 0, 0, 2, 4, 1, 32'hB, 32'hD, 2'b10, 32'h4);
    vecs[17] = mk(1, 2'b01, 1, 32'h77, 0, 0, 1, 5, 1, 2, 1, 32'hA, 32'hB, 2'b01, 32'h4);
    vecs[18] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 2'b11, 0);
    vecs[19] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 1, 0, 0, 2'b11, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].wen, vecs[i].wr0, vecs[i].wd0, vecs[i].wr1, vecs[i].wd1,
            vecs[i].ae, vecs[i].ar, vecs[i].rr0, vecs[i].rr1);
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("row%0d rdata0", i), rdata[31:0], vecs[i].ed0);
        check($sformatf("row%0d rdata1", i), rdata[63:32], vecs[i].ed1);
        check($sformatf("row%0d rready", i), {30'd0, rready}, {30'd0, vecs[i].erdy});
        check($sformatf("row%0d busy", i), busy, vecs[i].ebusy);
      end
      @(posedge clk); #1;
    end

    // Table ends with no writes since its last reset: architectural state is all zero.
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0; m_busy[i] = 0;
    end

    for (int c = 0; c < 500; c++) begin
      bit        rst, ae;
      bit [1:0]  w;
      bit [4:0]  wr0, wr1, ar, rr0, rr1;
      bit [31:0] wd0, wd1;
      logic [31:0] d0, d1;
      logic        y0, y1;

      rst = ($urandom_range(0, 49) == 0);
      w   = 2'($urandom);
      wr0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ar  = 5'($urandom_range(0, 7));
      rr0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rr1 = 5'($urandom_range(0, 7));
      ae  = ($urandom_range(0, 2) == 0);
      wd0 = $urandom;
      wd1 = $urandom;

      drive(rst, w, wr0, wd0, wr1, wd1, ae, ar, rr0, rr1);
      model_read(rst, w, wr0, wd0, wr1, wd1, rr0, d0, y0);
      model_read(rst, w, wr0, wd0, wr1, wd1, rr1, d1, y1);
      @(negedge clk);
      check($sformatf("rand%0d rdata0", c), rdata[31:0], d0);
      check($sformatf("rand%0d rdata1", c), rdata[63:32], d1);
      check($sformatf("rand%0d rready", c), {30'd0, rready}, {30'd0, y1, y0});
      check($sformatf("rand%0d busy", c), busy, model_busy());

      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          m_mem[i] = 0; m_busy[i] = 0;
        end
      end else begin
        if (w[0] && wr0 != 0) begin m_mem[wr0] = wd0; m_busy[wr0] = 0; end
        if (w[1] && wr1 != 0) begin m_mem[wr1] = wd1; m_busy[wr1] = 0; end
        if (ae && ar != 0) m_busy[ar] = 1;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
